// File: rtl/sa_autosa_reset_gen.sv
`default_nettype none
// ============================================================================
// Module   : sa_autosa_reset_gen
// Purpose  : Soft-reset sequencer for the AutoSA core: drain, assert, release.
// Revision : 1.0 - initial release
// ============================================================================
module sa_autosa_reset_gen #(
    parameter int CNT_W     = 8,
    parameter int MIN_PULSE = 16,
    parameter int DRAIN_TMO = 255,
    parameter int SYNC_TMO  = 63
) (
    input  logic             autosa_clk,
    input  logic             dla_reset_rstn,
    input  logic             sw_rst_req,
    input  logic [CNT_W-1:0] sw_rst_len,
    input  logic             core_idle,
    input  logic             synced_rstn,
    output logic             core_reset_rstn,
    output logic             drain_req,
    output logic             rst_busy,
    output logic             rst_done,
    output logic [1:0]       rst_tmo
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_drain   = 3'd1;
    localparam logic [2:0] c_st_assert  = 3'd2;
    localparam logic [2:0] c_st_release = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    localparam logic [CNT_W-1:0] c_min_pulse = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W:0]   c_drain_tmo = (CNT_W+1)'(DRAIN_TMO);
    localparam logic [CNT_W:0]   c_sync_tmo  = (CNT_W+1)'(SYNC_TMO);
    localparam logic [CNT_W:0]   c_one       = (CNT_W+1)'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_sat;
    logic [CNT_W-1:0] r_eff_len;
    logic [CNT_W-1:0] w_eff_len;
    logic             r_len_met;
    logic             r_sync_seen;
    logic             w_sync_low;
    logic [1:0]       r_tmo;
    logic             r_core_reset_rstn;
    logic             w_accept;
    logic             w_len_reached;
    logic             w_set_drain_tmo;
    logic             w_set_sync_tmo;
    logic             w_state_change;

    // Carry bit keeps "cycles elapsed" exact even when the counter is at its top value.
    assign w_cnt_inc      = {1'b0, r_cnt} + c_one;
    assign w_cnt_sat      = (&r_cnt) ? r_cnt : w_cnt_inc[CNT_W-1:0];
    assign w_eff_len      = (sw_rst_len < c_min_pulse) ? c_min_pulse : sw_rst_len;
    assign w_sync_low     = r_sync_seen | ~synced_rstn;
    assign w_state_change = (w_next_state != r_state);

    always_ff @(posedge autosa_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ASSERT runs in two phases: the pulse length, then (if synced_rstn has not
    // dropped yet) a restarted counter for the sync timeout.
    always_comb begin
        w_next_state    = r_state;
        w_accept        = 1'b0;
        w_len_reached   = 1'b0;
        w_set_drain_tmo = 1'b0;
        w_set_sync_tmo  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (sw_rst_req) begin
                    w_next_state = c_st_drain;
                    w_accept     = 1'b1;
                end
            end
            c_st_drain: begin
                if (core_idle) begin
                    w_next_state = c_st_assert;
                end else if (w_cnt_inc >= c_drain_tmo) begin
                    w_next_state    = c_st_assert;
                    w_set_drain_tmo = 1'b1;
                end
            end
            c_st_assert: begin
                if (!r_len_met) begin
                    if (w_cnt_inc >= {1'b0, r_eff_len}) begin
                        w_len_reached = 1'b1;
                        if (w_sync_low) begin
                            w_next_state = c_st_release;
                        end else if (c_sync_tmo == '0) begin
                            w_next_state   = c_st_release;
                            w_set_sync_tmo = 1'b1;
                        end
                    end
                end else if (w_sync_low) begin
                    w_next_state = c_st_release;
                end else if (w_cnt_inc >= c_sync_tmo) begin
                    w_next_state   = c_st_release;
                    w_set_sync_tmo = 1'b1;
                end
            end
            c_st_release: begin
                if (synced_rstn) begin
                    w_next_state = c_st_done;
                end else if (w_cnt_inc >= c_sync_tmo) begin
                    w_next_state   = c_st_idle;
                    w_set_sync_tmo = 1'b1;
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge autosa_clk or negedge dla_reset_rstn) begin
        if (!dla_reset_rstn) begin
            r_cnt             <= '0;
            r_eff_len         <= '0;
            r_len_met         <= 1'b0;
            r_sync_seen       <= 1'b0;
            r_tmo             <= 2'b00;
            r_core_reset_rstn <= 1'b1;
        end else begin
            r_core_reset_rstn <= (w_next_state != c_st_assert);

            if (w_state_change || w_len_reached) begin
                r_cnt <= '0;
            end else if (r_state != c_st_idle) begin
                r_cnt <= w_cnt_sat;
            end

            if (w_state_change) begin
                r_len_met   <= 1'b0;
                r_sync_seen <= 1'b0;
            end else begin
                if (w_len_reached) begin
                    r_len_met <= 1'b1;
                end
                if ((r_state == c_st_assert) && !synced_rstn) begin
                    r_sync_seen <= 1'b1;
                end
            end

            if (w_accept) begin
                r_eff_len <= w_eff_len;
                r_tmo     <= 2'b00;
            end else begin
                if (w_set_drain_tmo) begin
                    r_tmo[0] <= 1'b1;
                end
                if (w_set_sync_tmo) begin
                    r_tmo[1] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        drain_req = (r_state == c_st_drain);
        rst_busy  = (r_state != c_st_idle);
        rst_done  = (r_state == c_st_done);
    end

    assign core_reset_rstn = r_core_reset_rstn;
    assign rst_tmo         = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_sa_autosa_reset_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_autosa_reset_gen
// Purpose  : Scoreboard bench for sa_autosa_reset_gen; per-sequence outcome records.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_autosa_reset_gen;

    localparam int c_min_pulse = 16;
    localparam int c_drain_tmo = 255;
    localparam int c_sync_tmo  = 63;

    logic       autosa_clk;
    logic       dla_reset_rstn;
    logic       sw_rst_req;
    logic [7:0] sw_rst_len;
    logic       core_idle;
    logic       synced_rstn;
    logic       core_reset_rstn;
    logic       drain_req;
    logic       rst_busy;
    logic       rst_done;
    logic [1:0] rst_tmo;

    // sync_mode: 0 = track core_reset_rstn with 3-cycle delay, 1 = stuck high, 2 = stuck low
    int         sync_mode;
    logic [2:0] sync_pipe = 3'b111;

    typedef struct {
        int drain;
        int low;
        int rel;
        int done_n;
        int pulses;
        int tmo;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // measurement of the sequence currently observed
    bit   in_seq = 0;
    int   m_drain, m_low, m_rel, m_done, m_pulses;
    logic m_prev_core;

    sa_autosa_reset_gen #(
        .CNT_W    (8),
        .MIN_PULSE(c_min_pulse),
        .DRAIN_TMO(c_drain_tmo),
        .SYNC_TMO (c_sync_tmo)
    ) dut (
        .autosa_clk     (autosa_clk),
        .dla_reset_rstn (dla_reset_rstn),
        .sw_rst_req     (sw_rst_req),
        .sw_rst_len     (sw_rst_len),
        .core_idle      (core_idle),
        .synced_rstn    (synced_rstn),
        .core_reset_rstn(core_reset_rstn),
        .drain_req      (drain_req),
        .rst_busy       (rst_busy),
        .rst_done       (rst_done),
        .rst_tmo        (rst_tmo)
    );

    initial autosa_clk = 1'b0;
    always #5 autosa_clk = ~autosa_clk;

    always @(posedge autosa_clk) sync_pipe <= {sync_pipe[1:0], core_reset_rstn};

    assign synced_rstn = (sync_mode == 0) ? sync_pipe[2] : (sync_mode == 1);

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
        end
    endtask

    // Expected outcome of one sequence from its stimulus parameters.
    // d = number of leading DRAIN cycles with core_idle low.
    function automatic exp_t model(input int len, input int d, input int mode);
        exp_t e;
        int   eff;
        int   tmo0;
        int   tmo1;
        eff  = (len < c_min_pulse) ? c_min_pulse : len;
        tmo0 = (d + 1 > c_drain_tmo) ? 1 : 0;
        e.drain  = tmo0 ? c_drain_tmo : d + 1;
        e.pulses = 1;
        case (mode)
            0: begin e.low = eff;              e.rel = 4;          e.done_n = 1; tmo1 = 0; end
            1: begin e.low = eff + c_sync_tmo; e.rel = 1;          e.done_n = 1; tmo1 = 1; end
            default: begin e.low = eff;        e.rel = c_sync_tmo; e.done_n = 0; tmo1 = 1; end
        endcase
        e.tmo = tmo1 * 2 + tmo0;
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge autosa_clk);
            if (!dla_reset_rstn) begin
                in_seq = 0;
            end else if (rst_busy) begin
                if (!in_seq) begin
                    in_seq      = 1;
                    m_drain     = 0;
                    m_low       = 0;
                    m_rel       = 0;
                    m_done      = 0;
                    m_pulses    = 0;
                    m_prev_core = 1'b1;
                end
                if (drain_req) m_drain++;
                if (!core_reset_rstn) m_low++;
                if (!core_reset_rstn && m_prev_core) m_pulses++;
                if (core_reset_rstn && !drain_req && !rst_done) m_rel++;
                if (rst_done) m_done++;
                m_prev_core = core_reset_rstn;
            end else if (in_seq) begin
                in_seq = 0;
                check("seq_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("drain_cycles", m_drain, e.drain);
                    check("low_cycles", m_low, e.low);
                    check("release_cycles", m_rel, e.rel);
                    check("done_pulses", m_done, e.done_n);
                    check("low_pulses", m_pulses, e.pulses);
                    check("tmo_flags", int'(rst_tmo), e.tmo);
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || rst_busy) && n < 1200) begin
            @(negedge autosa_clk);
            n++;
        end
        check("seq_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic run_seq(input int len, input int d, input int mode, input bit extra_req);
        @(posedge autosa_clk);
        #1;
        sync_mode  = mode;
        sw_rst_len = 8'(len);
        core_idle  = (d == 0);
        sw_rst_req = 1'b1;
        q.push_back(model(len, d, mode));
        @(posedge autosa_clk);
        #1;
        sw_rst_req = 1'b0;
        @(negedge autosa_clk);
        check("accept_drain_req", drain_req, 1);
        check("accept_tmo_clear", int'(rst_tmo), 0);
        if (d == 0) begin
            @(negedge autosa_clk);
            check("latency_core_low", core_reset_rstn, 0);
            if (extra_req) begin
                repeat (4) @(posedge autosa_clk);
                #1 sw_rst_req = 1'b1;
                repeat (3) @(posedge autosa_clk);
                #1 sw_rst_req = 1'b0;
            end
        end else begin
            repeat (d) @(posedge autosa_clk);
            #1 core_idle = 1'b1;
        end
        wait_idle();
    endtask

    initial begin
        int n;
        dla_reset_rstn = 1'b0;
        sw_rst_req     = 1'b0;
        sw_rst_len     = 8'd0;
        core_idle      = 1'b1;
        sync_mode      = 0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge autosa_clk);
        @(negedge autosa_clk);
        check("reset_core_rstn", core_reset_rstn, 1);
        check("reset_drain_req", drain_req, 0);
        check("reset_busy", rst_busy, 0);
        check("reset_done", rst_done, 0);
        check("reset_tmo", int'(rst_tmo), 0);
        @(posedge autosa_clk);
        #1 dla_reset_rstn = 1'b1;

        run_seq(20, 0, 0, 1'b0);   // nominal
        run_seq(3, 0, 0, 1'b0);    // short length -> MIN_PULSE
        run_seq(0, 0, 0, 1'b0);    // zero length -> MIN_PULSE
        run_seq(255, 0, 0, 1'b0);  // maximum length honoured exactly
        run_seq(20, 300, 0, 1'b0); // drain timeout
        run_seq(20, 254, 0, 1'b0); // idle on the last allowed drain cycle
        run_seq(20, 0, 1, 1'b0);   // sync timeout in ASSERT
        run_seq(20, 0, 2, 1'b0);   // sync timeout in RELEASE, no done
        run_seq(24, 0, 0, 1'b1);   // request while busy is ignored

        // request held through DONE: ignored in DONE, accepted one IDLE cycle later
        @(posedge autosa_clk);
        #1;
        sync_mode  = 0;
        core_idle  = 1'b1;
        sw_rst_len = 8'd20;
        sw_rst_req = 1'b1;
        q.push_back(model(20, 0, 0));
        q.push_back(model(20, 0, 0));
        n = 0;
        do begin
            @(negedge autosa_clk);
            n++;
        end while (!rst_done && n < 200);
        check("b2b_done_seen", rst_done, 1);
        @(posedge autosa_clk);
        #1;
        @(negedge autosa_clk);
        check("b2b_idle_gap", rst_busy, 0);
        @(posedge autosa_clk);
        #1 sw_rst_req = 1'b0;
        @(negedge autosa_clk);
        check("b2b_restart", drain_req, 1);
        wait_idle();

        // asynchronous abort in ASSERT after a drain timeout has set rst_tmo[0]
        @(posedge autosa_clk);
        #1;
        sync_mode  = 1;
        core_idle  = 1'b0;
        sw_rst_len = 8'd20;
        sw_rst_req = 1'b1;
        @(posedge autosa_clk);
        #1 sw_rst_req = 1'b0;
        repeat (270) @(posedge autosa_clk);
        #1;
        check("abort_pre_core_low", core_reset_rstn, 0);
        check("abort_pre_tmo", int'(rst_tmo), 1);
        #2 dla_reset_rstn = 1'b0;
        #1;
        check("abort_core_rstn", core_reset_rstn, 1);
        check("abort_busy", rst_busy, 0);
        check("abort_drain_req", drain_req, 0);
        check("abort_tmo", int'(rst_tmo), 0);
        sync_mode  = 0;
        core_idle  = 1'b1;
        sw_rst_len = 8'd0;
        sw_rst_req = 1'b1;
        repeat (2) @(negedge autosa_clk);
        check("abort_hold_done", rst_done, 0);
        check("abort_hold_busy", rst_busy, 0);
        q.push_back(model(0, 0, 0));
        @(posedge autosa_clk);
        #1 dla_reset_rstn = 1'b1;
        @(negedge autosa_clk);
        check("post_reset_still_idle", rst_busy, 0);
        @(posedge autosa_clk);
        #1 sw_rst_req = 1'b0;
        @(negedge autosa_clk);
        check("post_reset_start", drain_req, 1);
        wait_idle();

        for (int i = 0; i < 10; i++) begin
            int len;
            int d;
            int mode;
            case ($urandom_range(0, 5))
                0: len = 0;
                1: len = 3;
                2: len = 16;
                3: len = 17;
                4: len = 255;
                default: len = int'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 3))
                0: d = 0;
                1: d = int'($urandom_range(1, 10));
                2: d = 254;
                default: d = 255;
            endcase
            mode = int'($urandom_range(0, 2));
            run_seq(len, d, mode, 1'b0);
        end

        check("queue_empty_end", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sa_autosa_reset_gen.md
SA_AUTOSA_RESET_GEN -- requirements
Module: sa_autosa_reset_gen

Interface
- REQ-001: Parameter CNT_W, default 8: width of the pulse-length and timeout counters.
- REQ-002: Parameter MIN_PULSE, default 16: minimum core reset assertion length, in cycles.
- REQ-003: Parameter DRAIN_TMO, default 255: maximum cycles spent waiting for the core to go idle.
- REQ-004: Parameter SYNC_TMO, default 63: maximum cycles spent waiting for the synced_rstn feedback.
- REQ-005: autosa_clk  in  1  sole clock; all flops are rising-edge.
- REQ-006: dla_reset_rstn  in  1  reset; asynchronous assertion, active-low.
- REQ-007: sw_rst_req  in  1  soft-reset request; sampled only in IDLE.
- REQ-008: sw_rst_len  in  CNT_W  requested assertion length, in cycles.
- REQ-009: core_idle  in  1  core quiesced indication.
- REQ-010: synced_rstn  in  1  synchronized core reset fed back from the reset synchronizer/combiner.
- REQ-011: core_reset_rstn  out  1  generated core reset; registered; active-low.
- REQ-012: drain_req  out  1  request for the core to quiesce.
- REQ-013: rst_busy  out  1  high in every state except IDLE.
- REQ-014: rst_done  out  1  one-cycle pulse marking successful sequence completion.
- REQ-015: rst_tmo  out  2  sticky timeout flags; bit0 = drain timeout, bit1 = sync timeout.

Function
- REQ-016: The block SHALL implement a Moore FSM with states IDLE, DRAIN, ASSERT, RELEASE, DONE; all outputs SHALL be registered or decoded from state only.
- REQ-017: In IDLE with sw_rst_req=1, the block SHALL:
  - latch eff_len = max(sw_rst_len, MIN_PULSE); sw_rst_len=0 therefore yields MIN_PULSE;
  - clear rst_tmo;
  - enter DRAIN on the next edge.
- REQ-018: DRAIN SHALL drive drain_req=1 and increment a wait counter starting at 0.
- REQ-019: DRAIN SHALL move to ASSERT on the first cycle core_idle=1.
- REQ-020: If the wait counter reaches DRAIN_TMO first, DRAIN SHALL set rst_tmo[0] and move to ASSERT anyway.
- REQ-021: ASSERT SHALL drive core_reset_rstn=0 and drain_req=0.
- REQ-022: ASSERT SHALL exit to RELEASE only when both hold:
  - at least eff_len ASSERT cycles have elapsed;
  - synced_rstn=0 has been observed at least once during ASSERT.
- REQ-023: If synced_rstn never goes low, the block SHALL set rst_tmo[1] after eff_len+SYNC_TMO ASSERT cycles and move to RELEASE.
- REQ-024: RELEASE SHALL drive core_reset_rstn=1.
- REQ-025: RELEASE SHALL move to DONE on the first cycle synced_rstn=1.
- REQ-026: After SYNC_TMO RELEASE cycles without synced_rstn=1, RELEASE SHALL set rst_tmo[1] and return to IDLE without a rst_done pulse.
- REQ-027: DONE SHALL assert rst_done for exactly one cycle, then return to IDLE.
- REQ-028: Latency: with sw_rst_req at edge N and core_idle=1 throughout:
  - drain_req=1 in cycle N+1;
  - core_reset_rstn=0 from cycle N+2.
- REQ-029: sw_rst_req SHALL be ignored outside IDLE; requests are neither queued nor merged.
- REQ-030: A request in the DONE cycle SHALL be ignored; a request held through the cycle following DONE SHALL start a new sequence.
- REQ-031: Counters SHALL saturate and never wrap.
- REQ-032: Comparisons SHALL be unsigned at CNT_W bits; sw_rst_len=2^CNT_W-1 SHALL be honoured exactly.
- REQ-033: rst_tmo bits SHALL hold until the next accepted request.

Reset
- REQ-034: While dla_reset_rstn=0, the block SHALL force, asynchronously:
  - state=IDLE and counters=0;
  - core_reset_rstn=1;
  - drain_req=0, rst_busy=0, rst_done=0, rst_tmo=0.
- REQ-035: Deassertion of dla_reset_rstn SHALL be taken synchronously; the FSM SHALL leave IDLE no earlier than the first edge after release.
- REQ-036: dla_reset_rstn asserted mid-sequence, including during ASSERT, SHALL abort to the reset values above with no rst_done pulse.

Verification
- REQ-037: Nominal: sw_rst_len=20, core_idle=1, synced_rstn tracking core_reset_rstn with 3-cycle delay -> drain_req for 1 cycle; core_reset_rstn low for exactly 20 cycles; rst_done pulse 4 cycles after release; rst_tmo=0.
- REQ-038: Short length: sw_rst_len=3 -> core_reset_rstn low for exactly MIN_PULSE=16 cycles.
- REQ-039: Drain timeout: core_idle stuck 0 -> ASSERT entered after 255 DRAIN cycles; rst_tmo=01; sequence still completes with rst_done.
- REQ-040: Sync timeout: synced_rstn stuck 1 -> ASSERT lasts eff_len+63 cycles; rst_tmo[1]=1; RELEASE completes (synced_rstn=1); rst_done pulses.
- REQ-041: Busy request: second sw_rst_req during ASSERT -> ignored; exactly one low pulse on core_reset_rstn; exactly one rst_done.
- REQ-042: Mid-sequence reset: dla_reset_rstn low during ASSERT -> core_reset_rstn=1 and rst_busy=0 immediately (asynchronous); no rst_done.
